// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: key conditioning, run/pause/lap FSM, counter enable/clear
// generation and the registered value handed to the BCD stage.
module stopwatch_ctrl #(
  parameter int WIDTH      = 16,
  parameter int DEB_CYCLES = 500000
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             key_ss_n,
  input  logic             key_lap_n,
  input  logic             tick,
  input  logic [WIDTH-1:0] count,
  output logic             cnt_en,
  output logic             cnt_clr,
  output logic [WIDTH-1:0] disp_value,
  output logic             running,
  output logic             frozen,
  output logic             overflow
);

  localparam int            DW       = $clog2(DEB_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_LAP   = 2'd3;

  // Index 0 is start/stop, index 1 is lap/clear.
  logic [1:0] key_raw;
  logic [1:0] press;

  assign key_raw = {key_lap_n, key_ss_n};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_key
      logic          sync1_reg;
      logic          sync2_reg;
      logic          acc_reg;
      logic          acc_d_reg;
      logic          press_reg;
      logic [DW-1:0] deb_cnt_reg;

      always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
          sync1_reg   <= 1'b1;
          sync2_reg   <= 1'b1;
          acc_reg     <= 1'b1;
          acc_d_reg   <= 1'b1;
          press_reg   <= 1'b0;
          deb_cnt_reg <= '0;
        end else begin
          sync1_reg <= key_raw[gi];
          sync2_reg <= sync1_reg;
          // Any sample that agrees with the accepted level restarts the run.
          if (sync2_reg == acc_reg) begin
            deb_cnt_reg <= '0;
          end else if (deb_cnt_reg == DEB_LAST) begin
            deb_cnt_reg <= '0;
            acc_reg     <= sync2_reg;
          end else begin
            deb_cnt_reg <= deb_cnt_reg + DW'(1);
          end
          acc_d_reg <= acc_reg;
          press_reg <= acc_d_reg & ~acc_reg;
        end
      end

      assign press[gi] = press_reg;
    end
  endgenerate

  logic             ss_press;
  logic             lap_press;
  logic [1:0]       state_reg;
  logic [1:0]       state_next;
  logic             clr_next;
  logic [WIDTH-1:0] hold_reg;
  logic             active;
  logic             sat;

  assign ss_press  = press[0];
  assign lap_press = press[1] & ~press[0];
  assign active    = (state_reg == ST_RUN) || (state_reg == ST_LAP);
  assign sat       = &count;

  always_comb begin
    state_next = state_reg;
    clr_next   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (ss_press) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (ss_press)       state_next = ST_PAUSE;
        else if (lap_press) state_next = ST_LAP;
      end
      ST_LAP: begin
        if (ss_press)       state_next = ST_PAUSE;
        else if (lap_press) state_next = ST_RUN;
      end
      ST_PAUSE: begin
        if (ss_press) begin
          state_next = ST_RUN;
        end else if (lap_press) begin
          state_next = ST_IDLE;
          clr_next   = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      hold_reg   <= '0;
      cnt_en     <= 1'b0;
      cnt_clr    <= 1'b1;
      disp_value <= '0;
      overflow   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if ((state_reg == ST_RUN) && lap_press) hold_reg <= count;
      cnt_en  <= tick & active & ~sat;
      cnt_clr <= clr_next;
      // Clearing wins: the flag drops together with the clear pulse.
      if (clr_next)                   overflow <= 1'b0;
      else if (tick && active && sat) overflow <= 1'b1;
      disp_value <= (state_reg == ST_LAP) ? hold_reg : count;
    end
  end

  assign running = active;
  assign frozen  = (state_reg == ST_LAP);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DEB_CYCLES=4; the bench plays the
// role of the external counter by driving count directly.
module tb_stopwatch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_ss_n;
  logic        key_lap_n;
  logic        tick;
  logic [15:0] count;
  logic        cnt_en;
  logic        cnt_clr;
  logic [15:0] disp_value;
  logic        running;
  logic        frozen;
  logic        overflow;

  int n_total = 0;
  int n_pass  = 0;
  int en_seen = 0;
  int en_base = 0;
  bit run_seen = 1'b0;

  stopwatch_ctrl #(.WIDTH(16), .DEB_CYCLES(4)) dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .key_ss_n  (key_ss_n),
    .key_lap_n (key_lap_n),
    .tick      (tick),
    .count     (count),
    .cnt_en    (cnt_en),
    .cnt_clr   (cnt_clr),
    .disp_value(disp_value),
    .running   (running),
    .frozen    (frozen),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cnt_en)  en_seen++;
    if (running) run_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) begin
      n_pass++;
      $display("ok   %-14s = %0h", tag, obs);
    end else begin
      $display("FAIL %-14s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Press pulse lands 7 edges after the pin edge, state moves on edge 8.
  task automatic push(input bit ss, input bit lap);
    if (ss)  key_ss_n  = 1'b0;
    if (lap) key_lap_n = 1'b0;
    step(8);
  endtask

  task automatic release_keys();
    key_ss_n  = 1'b1;
    key_lap_n = 1'b1;
    step(12);
  endtask

  initial begin
    reset     = 1'b1;
    key_ss_n  = 1'b1;
    key_lap_n = 1'b1;
    tick      = 1'b0;
    count     = 16'h0000;
    step(2);
    chk("rst_cnt_clr", cnt_clr, 1);
    chk("rst_cnt_en", cnt_en, 0);
    chk("rst_disp", disp_value, 0);
    chk("rst_running", running, 0);
    chk("rst_frozen", frozen, 0);
    chk("rst_overflow", overflow, 0);
    reset = 1'b0;
    step(1);
    chk("clr_drop", cnt_clr, 0);

    // Bounce shorter than the debounce window must never register.
    run_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      key_ss_n = 1'b0;
      step(3);
      key_ss_n = 1'b1;
      step(3);
    end
    step(15);
    chk("bounce_seen", run_seen, 0);
    chk("bounce_idle", running, 0);

    // Clean start press: running rises exactly 8 edges after the pin edge.
    key_ss_n = 1'b0;
    step(7);
    chk("run_early", running, 0);
    step(1);
    chk("run_rise", running, 1);
    step(12);
    key_ss_n = 1'b1;
    step(12);
    chk("run_held", running, 1);

    en_base = en_seen;
    for (int i = 0; i < 5; i++) begin
      tick = 1'b1;
      step(1);
      chk("tick_en", cnt_en, 1);
      tick = 1'b0;
      step(1);
      chk("tick_en_off", cnt_en, 0);
      step(8);
    end
    chk("en_pulses", en_seen - en_base, 5);
    chk("no_ovf", overflow, 0);

    // Lap freezes the display at the count seen in the press-pulse cycle.
    count = 16'h0123;
    key_lap_n = 1'b0;
    step(8);
    chk("lap_frozen", frozen, 1);
    chk("lap_running", running, 1);
    count = 16'h0130;
    step(1);
    chk("lap_hold", disp_value, 16'h0123);
    step(3);
    chk("lap_hold2", disp_value, 16'h0123);
    key_lap_n = 1'b1;
    step(12);
    key_lap_n = 1'b0;
    step(8);
    chk("unlap_frozen", frozen, 0);
    chk("unlap_lag", disp_value, 16'h0123);
    step(1);
    chk("unlap_live", disp_value, 16'h0130);
    release_keys();

    // Pause drops ticks; lap from pause clears.
    push(1, 0);
    chk("pause_run", running, 0);
    chk("pause_frozen", frozen, 0);
    release_keys();
    tick = 1'b1;
    step(1);
    chk("pause_no_en", cnt_en, 0);
    tick = 1'b0;
    step(1);
    push(0, 1);
    chk("clr_pulse", cnt_clr, 1);
    chk("clr_idle", running, 0);
    chk("clr_no_ovf", overflow, 0);
    step(1);
    chk("clr_single", cnt_clr, 0);
    release_keys();

    // Saturation sets the sticky flag instead of enabling the counter.
    push(1, 0);
    release_keys();
    chk("sat_run", running, 1);
    count = 16'hFFFF;
    tick = 1'b1;
    step(1);
    chk("sat_no_en", cnt_en, 0);
    chk("sat_ovf", overflow, 1);
    tick = 1'b0;
    step(1);
    chk("sat_ovf_stick", overflow, 1);
    push(1, 0);
    chk("sat_pause", running, 0);
    chk("sat_ovf_pause", overflow, 1);
    release_keys();
    push(0, 1);
    chk("sat_clr", cnt_clr, 1);
    chk("sat_ovf_clr", overflow, 0);
    step(1);
    chk("sat_clr_off", cnt_clr, 0);
    release_keys();

    // Simultaneous presses: start/stop wins, hold register untouched.
    count = 16'h0456;
    push(1, 0);
    release_keys();
    chk("both_pre_run", running, 1);
    push(1, 1);
    chk("both_pause", running, 0);
    chk("both_not_lap", frozen, 0);
    chk("both_hold", dut.hold_reg, 16'h0123);
    step(1);
    chk("both_disp", disp_value, 16'h0456);
    release_keys();

    // Asynchronous reset in the middle of a run.
    push(1, 0);
    release_keys();
    tick = 1'b1;
    step(1);
    chk("pre_rst_en", cnt_en, 1);
    tick = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_cnt_en", cnt_en, 0);
    chk("arst_cnt_clr", cnt_clr, 1);
    chk("arst_disp", disp_value, 0);
    chk("arst_running", running, 0);
    chk("arst_frozen", frozen, 0);
    chk("arst_overflow", overflow, 0);
    step(2);
    reset = 1'b0;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
